// File: rtl/riscv_pkg.sv
// Shared fetch-path types and helpers: instruction/PC widths, the fetch queue
// entry layout and PC arithmetic used by the fetch stage.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifetch_queue_chk.sv
// Protocol and bookkeeping checks for ifetch_queue: response credit, queue
// space guarantee and in-flight/drop accounting balance.
module ifetch_queue_chk #(
   parameter int DEPTH  = 4,
   parameter int CW     = 3,
   parameter int IFL_CW = 2
) (
   input logic              clk,
   input logic              rst_n,
   input logic              imem_rsp_valid,
   input logic              rsp_keep,
   input logic              ifl_empty,
   input logic [CW-1:0]     outstanding,
   input logic [CW-1:0]     drop_cnt,
   input logic [CW-1:0]     occupancy,
   input logic [IFL_CW-1:0] ifl_count
);

   localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

   a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (outstanding != {CW{1'b0}}));

   a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (({1'b0, occupancy} + {1'b0, outstanding}) <= L_DEPTH));

   a_inflight_balance: assert property (@(posedge clk) disable iff (!rst_n)
      ((CW'(ifl_count) + drop_cnt) == outstanding));

   a_kept_rsp_has_pc: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_keep |-> !ifl_empty);

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH need not be a power
// of two. Used for the fetch queue and for the in-flight PC tracker.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  logic [WIDTH-1:0]       i_data,
   output logic [WIDTH-1:0]       o_data,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr_en;
   logic             w_rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? {PW{1'b0}} : p + PW'(1'b1);
   endfunction

   assign w_wr_en = i_push & ~i_flush;
   assign w_rd_en = i_pop & ~i_flush & (r_count != {CW{1'b0}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else if (w_wr_en) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Flush only rewinds pointers; stale storage is never visible while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else if (i_flush) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == {CW{1'b0}});

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage with prefetch queue and redirect flush.
// Optional IFQ_BYPASS_EN: zero-latency response-to-decode path when queue empty.
module ifetch_queue
   import riscv_pkg::*;
#(
   parameter int              DEPTH           = 4,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [XLEN-1:0]        imem_addr,
   input  logic                   imem_rsp_valid,
   input  logic [ILEN-1:0]        imem_rsp_data,
   input  logic                   redirect_valid,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic                   dec_valid,
   input  logic                   dec_ready,
   output logic [ILEN-1:0]        dec_instr,
   output logic [XLEN-1:0]        dec_pc,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int CW     = $clog2(DEPTH) + 1;
   localparam int IFL_CW = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CW:0]   L_DEPTH = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] L_MAXO  = CW'(MAX_OUTSTANDING);

   logic [XLEN-1:0]   r_fetch_pc;
   logic [CW-1:0]     r_outstanding;
   logic [CW-1:0]     r_drop_cnt;

   logic [CW-1:0]     w_occ;
   logic              w_q_empty;
   logic              w_q_push;
   logic              w_q_pop;
   fetch_entry_t      w_q_din;
   fetch_entry_t      w_q_head;
   fetch_entry_t      w_dec_entry;
   logic              w_dec_valid;
   logic [XLEN-1:0]   w_ifl_pc;
   logic [IFL_CW-1:0] w_ifl_count;
   logic              w_ifl_empty;
   logic [CW:0]       w_credit_sum;
   logic              w_req_valid;
   logic              w_req_fire;
   logic              w_rsp_drop;
   logic              w_rsp_keep;

   // Credit rule: outstanding responses always have a guaranteed queue slot.
   always_comb begin
      w_credit_sum = {1'b0, w_occ} + {1'b0, r_outstanding};
      if (rst_n && !redirect_valid && (w_credit_sum < L_DEPTH) && (r_outstanding < L_MAXO)) begin
         w_req_valid = 1'b1;
      end else begin
         w_req_valid = 1'b0;
      end
   end

   assign w_req_fire = w_req_valid & imem_req_ready;
   assign w_rsp_drop = (r_drop_cnt != {CW{1'b0}});
   assign w_rsp_keep = rst_n & imem_rsp_valid & ~w_rsp_drop & ~redirect_valid;
   assign w_q_din    = '{instr: imem_rsp_data, pc: w_ifl_pc};
   assign w_q_pop    = ~w_q_empty & dec_ready & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
   logic w_byp;

   // Empty queue: the kept response is shown to decode in the same cycle.
   always_comb begin
      w_byp       = w_q_empty & w_rsp_keep;
      w_dec_valid = ~w_q_empty | w_byp;
      if (w_q_empty) begin
         w_dec_entry = w_q_din;
      end else begin
         w_dec_entry = w_q_head;
      end
      w_q_push = w_rsp_keep & ~(w_byp & dec_ready);
   end
`else
   assign w_dec_valid = ~w_q_empty;
   assign w_dec_entry = w_q_head;
   assign w_q_push    = w_rsp_keep;
`endif

   // Drop count on redirect reflects every response still owed by imem.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= {CW{1'b0}};
         r_drop_cnt    <= {CW{1'b0}};
      end else begin
         if (redirect_valid) begin
            r_fetch_pc <= align_pc(redirect_pc);
            r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
         end else begin
            if (w_req_fire) r_fetch_pc <= next_pc(r_fetch_pc);
            if (imem_rsp_valid && w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1'b1);
         end
         r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
      end
   end

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_q_push),
      .i_pop   (w_q_pop),
      .i_flush (redirect_valid),
      .i_data  (w_q_din),
      .o_data  (w_q_head),
      .o_count (w_occ),
      .o_empty (w_q_empty)
   );

   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTSTANDING)
   ) u_inflight (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_req_fire),
      .i_pop   (w_rsp_keep),
      .i_flush (redirect_valid),
      .i_data  (r_fetch_pc),
      .o_data  (w_ifl_pc),
      .o_count (w_ifl_count),
      .o_empty (w_ifl_empty)
   );

   ifetch_queue_chk #(
      .DEPTH  (DEPTH),
      .CW     (CW),
      .IFL_CW (IFL_CW)
   ) u_chk (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_rsp_valid (imem_rsp_valid),
      .rsp_keep       (w_rsp_keep),
      .ifl_empty      (w_ifl_empty),
      .outstanding    (r_outstanding),
      .drop_cnt       (r_drop_cnt),
      .occupancy      (w_occ),
      .ifl_count      (w_ifl_count)
   );

   assign imem_req_valid = w_req_valid;
   assign imem_addr      = r_fetch_pc;
   assign dec_valid      = w_dec_valid;
   assign dec_instr      = w_dec_entry.instr;
   assign dec_pc         = w_dec_entry.pc;
   assign occupancy      = w_occ;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: random imem/decode/redirect stimulus
// against a queue-level reference model of the fetch stream.
module tb_ifetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          MAXO     = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [2:0]  occupancy;

   ifetch_queue #(
      .DEPTH           (DEPTH),
      .RESET_PC        (RESET_PC),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .occupancy      (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; int due; int ep; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   req_t        pend[$];     // requests accepted by imem, response not yet returned
   exp_t        expq[$];     // instructions decode should still receive, in order
   logic [31:0] pop_log[$];  // PCs actually consumed by decode
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          rel_cyc = 0;
   int          epoch = 0;
   int          last_due = -1;
   int          vis_cnt = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   int          p_dec = 100;
   int          p_req = 100;
   bit          mon_en = 1'b0;
   logic [31:0] model_pc = RESET_PC;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs at posedge+1, check, update the model.
   task automatic step(input bit redir, input logic [31:0] rpc);
      bit   rsp_now;
      bit   exp_req;
      bit   fire;
      int   due;
      req_t r;
      redirect_valid = redir;
      redirect_pc    = rpc;
      dec_ready      = ($urandom_range(99) < p_dec);
      imem_req_ready = ($urandom_range(99) < p_req);
      rsp_now        = (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? mem_word(pend[0].pc) : $urandom;
      #1;
      exp_req = (expq.size() + pend.size() < DEPTH) && (pend.size() < MAXO) && !redir;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (imem_req_valid) chk("imem_addr", imem_addr, model_pc);
      chk("occupancy", 32'(occupancy), 32'(expq.size()));
      vis_cnt = expq.size();
      fire = imem_req_valid && imem_req_ready;
      if (rsp_now) begin
         r = pend.pop_front();
         if (!redir && r.ep == epoch) expq.push_back('{pc: r.pc, instr: mem_word(r.pc)});
      end
      if (redir) begin
         expq.delete();
         epoch++;
         model_pc = rpc & 32'hFFFF_FFFC;
      end else if (fire) begin
         due = cyc + $urandom_range(lat_hi, lat_lo);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend.push_back('{pc: model_pc, due: due, ep: epoch});
         model_pc = model_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_req_ready = 1'b0;
      dec_ready      = 1'b0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_dec_instr", dec_instr, 32'd0);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      pend.delete();
      expq.delete();
      epoch++;
      model_pc = RESET_PC;
      last_due = -1;
      vis_cnt  = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      rel_cyc = cyc;
      mon_en  = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every decode handshake.
   initial begin
      exp_t        e;
      bit          held_v = 1'b0;
      logic [31:0] held_pc = 32'h0;
      logic [31:0] held_instr = 32'h0;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            chk("dec_valid", 32'(dec_valid), 32'(vis_cnt > 0));
            if (held_v) begin
               chk("stall_pc", dec_pc, held_pc);
               chk("stall_instr", dec_instr, held_instr);
            end
            held_v = 1'b0;
            if (dec_valid && !redirect_valid) begin
               if (dec_ready) begin
                  if (expq.size() == 0) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL dec_pop: got pc %h expected no instruction", dec_pc);
                  end else begin
                     e = expq.pop_front();
                     chk("dec_pc", dec_pc, e.pc);
                     chk("dec_instr", dec_instr, e.instr);
                     pop_log.push_back(dec_pc);
                  end
               end else begin
                  held_v     = 1'b1;
                  held_pc    = dec_pc;
                  held_instr = dec_instr;
               end
            end
         end else begin
            held_v = 1'b0;
         end
      end
   end

   initial begin
      int first_dv;
      int idx;
      bit found;
      rst_n          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_req_ready = 1'b0;
      dec_ready      = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Latency 1, always ready: first decode in the third cycle after release.
      lat_lo = 1; lat_hi = 1; p_dec = 100; p_req = 100;
      first_dv = -1;
      for (int k = 0; k < 12; k++) begin
         if (dec_valid && first_dv < 0) first_dv = cyc - rel_cyc;
         step(1'b0, 32'h0);
      end
      chk("first_dec_valid_cycle", 32'(first_dv), 32'd2);
      if (pop_log.size() >= 3) begin
         chk("seq_pc0", pop_log[0], 32'h0000_0000);
         chk("seq_pc1", pop_log[1], 32'h0000_0004);
         chk("seq_pc2", pop_log[2], 32'h0000_0008);
      end else begin
         chk("seq_pop_count", 32'(pop_log.size()), 32'd3);
      end

      // Decode stall fills the queue, then drains without loss.
      p_dec = 0;
      repeat (10) step(1'b0, 32'h0);
      chk("full_occupancy", 32'(occupancy), 32'(DEPTH));
      chk("full_req_valid", 32'(imem_req_valid), 32'd0);
      chk("full_dec_valid", 32'(dec_valid), 32'd1);
      p_dec = 100;
      repeat (20) step(1'b0, 32'h0);

      // Redirect with two requests in flight and no response this cycle.
      lat_lo = 3; lat_hi = 3;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         if (pend.size() == 2 && pend[0].due > cyc) found = 1'b1;
         else step(1'b0, 32'h0);
      end
      chk("redir2_setup_found", 32'(found), 32'd1);
      idx = pop_log.size();
      step(1'b1, 32'h0000_0102);
      chk("redir2_next_addr", imem_addr, 32'h0000_0100);
      repeat (15) step(1'b0, 32'h0);
      if (pop_log.size() > idx) chk("redir2_first_pc", pop_log[idx], 32'h0000_0100);
      else chk("redir2_pop_count", 32'(pop_log.size() - idx), 32'd1);

      // Redirect coinciding with a response and a decode handshake.
      lat_lo = 2; lat_hi = 2;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         if (pend.size() == 2 && pend[0].due <= cyc) found = 1'b1;
         else step(1'b0, 32'h0);
      end
      chk("redir_rsp_setup_found", 32'(found), 32'd1);
      step(1'b1, 32'h0000_0200);
      chk("redir_rsp_dec_valid", 32'(dec_valid), 32'd0);
      chk("redir_rsp_occupancy", 32'(occupancy), 32'd0);
      repeat (15) step(1'b0, 32'h0);

      // PC wrap from 0xFFFF_FFFC to 0.
      lat_lo = 1; lat_hi = 2;
      idx = pop_log.size();
      step(1'b1, 32'hFFFF_FFF4);
      repeat (20) step(1'b0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         if (pop_log.size() > idx + k) chk("wrap_pc", pop_log[idx + k], 32'hFFFF_FFF4 + 32'(4 * k));
         else chk("wrap_pop_count", 32'(pop_log.size() - idx), 32'(k + 1));
      end

      // Reset in mid-stream: entries held and requests outstanding.
      lat_lo = 3; lat_hi = 3; p_dec = 0;
      repeat (5) step(1'b0, 32'h0);
      do_reset();
      p_dec = 100; lat_lo = 1; lat_hi = 1;
      idx = pop_log.size();
      repeat (10) step(1'b0, 32'h0);
      if (pop_log.size() > idx) chk("post_reset_first_pc", pop_log[idx], RESET_PC);
      else chk("post_reset_pop_count", 32'(pop_log.size() - idx), 32'd1);

      // Random traffic: latencies, stalls, back-pressure, redirects, one reset.
      for (int k = 0; k < 2000; k++) begin
         if (k % 50 == 0) begin
            lat_lo = 1;
            lat_hi = $urandom_range(4, 1);
            p_dec  = $urandom_range(100, 20);
            p_req  = $urandom_range(100, 30);
         end
         if (k == 1000) do_reset();
         if ($urandom_range(99) < 3) step(1'b1, $urandom);
         else step(1'b0, 32'h0);
      end

      // Drain everything still owed.
      p_dec = 100; p_req = 0; lat_lo = 1; lat_hi = 1;
      repeat (30) step(1'b0, 32'h0);
      chk("drain_occupancy", 32'(occupancy), 32'd0);
      chk("drain_dec_valid", 32'(dec_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
